// File: rtl/median_partition_stage.sv
// One quickselect pass: three-way partition of a pixel window around a pivot,
// then a header plus the surviving group for the next identical stage.
//
// state  | meaning
// IDLE   | waiting for a config word
// FILL   | popping `size` pixels into the lower/larger buffers
// DECIDE | choosing the group that holds the target rank, registering the header
// HDR    | pushing the header
// SEND   | forwarding the selected group in arrival order
module median_partition_stage #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1024,
  parameter int SIZE_W = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_cfg_pivot,
  input  logic [SIZE_W-1:0] in_cfg_size,
  input  logic [SIZE_W-1:0] in_cfg_rank,
  input  logic              in_cfg_empty,
  output logic              in_cfg_rd,
  input  logic [DATA_W-1:0] in_px,
  input  logic              in_px_empty,
  output logic              in_px_rd,
  output logic [DATA_W-1:0] out_hdr_pivot,
  output logic [SIZE_W-1:0] out_hdr_size,
  output logic [SIZE_W-1:0] out_hdr_rank,
  output logic              out_hdr_found,
  output logic [DATA_W-1:0] out_hdr_median,
  output logic              out_hdr_wr,
  input  logic              out_hdr_full,
  output logic [DATA_W-1:0] out_px,
  output logic              out_px_wr,
  input  logic              out_px_full,
  output logic              busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {IDLE, FILL, DECIDE, HDR, SEND} state_t;

  state_t            state;
  logic [DATA_W-1:0] pivot_q;
  logic [SIZE_W-1:0] size_q;
  logic [SIZE_W-1:0] rank_q;
  logic [SIZE_W-1:0] fill_cnt;
  logic [SIZE_W-1:0] lower_cnt;
  logic [SIZE_W-1:0] equal_cnt;
  logic [SIZE_W-1:0] larger_cnt;
  logic [SIZE_W-1:0] send_idx;
  logic [DATA_W-1:0] lower_min;
  logic [DATA_W-1:0] lower_max;
  logic [DATA_W-1:0] larger_min;
  logic [DATA_W-1:0] larger_max;
  logic              sel_larger;

  logic [DATA_W-1:0] lower_buf  [DEPTH];
  logic [DATA_W-1:0] larger_buf [DEPTH];

  // Reset gates the config pop so nothing is reported during reset.
  assign in_cfg_rd  = reset && (state == IDLE) && !in_cfg_empty;
  assign in_px_rd   = (state == FILL) && !in_px_empty;
  assign out_hdr_wr = (state == HDR) && !out_hdr_full;
  assign out_px_wr  = (state == SEND) && !out_px_full;
  assign busy       = (state != IDLE);

  logic px_lt;
  logic px_gt;
  assign px_lt = in_px < pivot_q;
  assign px_gt = in_px > pivot_q;

  logic [SIZE_W-1:0] size_c;
  logic [SIZE_W-1:0] rank_c;
  assign size_c = (in_cfg_size > SIZE_W'(DEPTH)) ? SIZE_W'(DEPTH) : in_cfg_size;
  assign rank_c = (size_c == '0) ? '0 :
                  (in_cfg_rank >= size_c) ? size_c - SIZE_W'(1) : in_cfg_rank;

  // Group selection; one extra bit keeps lower+equal from wrapping.
  logic [SIZE_W:0]   lower_ext;
  logic [SIZE_W:0]   lower_equal_ext;
  logic [SIZE_W:0]   rank_ext;
  logic              pick_lower;
  logic              pick_equal;
  logic [SIZE_W-1:0] pick_cnt;
  logic [SIZE_W-1:0] rank_larger;
  logic [DATA_W-1:0] pick_min;
  logic [DATA_W-1:0] pick_max;

  assign lower_ext       = {1'b0, lower_cnt};
  assign lower_equal_ext = lower_ext + {1'b0, equal_cnt};
  assign rank_ext        = {1'b0, rank_q};
  assign pick_lower      = rank_ext < lower_ext;
  assign pick_equal      = !pick_lower && (rank_ext < lower_equal_ext);
  assign pick_cnt        = pick_lower ? lower_cnt : larger_cnt;
  assign pick_min        = pick_lower ? lower_min : larger_min;
  assign pick_max        = pick_lower ? lower_max : larger_max;
  assign rank_larger     = rank_q - lower_cnt - equal_cnt;

  assign out_px = (state != SEND) ? '0 :
                  sel_larger ? larger_buf[send_idx[IDX_W-1:0]] : lower_buf[send_idx[IDX_W-1:0]];

  always_ff @(posedge clock) begin
    if (in_px_rd && px_lt) lower_buf[lower_cnt[IDX_W-1:0]] <= in_px;
    if (in_px_rd && px_gt) larger_buf[larger_cnt[IDX_W-1:0]] <= in_px;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      pivot_q        <= '0;
      size_q         <= '0;
      rank_q         <= '0;
      fill_cnt       <= '0;
      lower_cnt      <= '0;
      equal_cnt      <= '0;
      larger_cnt     <= '0;
      send_idx       <= '0;
      lower_min      <= '0;
      lower_max      <= '0;
      larger_min     <= '0;
      larger_max     <= '0;
      sel_larger     <= 1'b0;
      out_hdr_pivot  <= '0;
      out_hdr_size   <= '0;
      out_hdr_rank   <= '0;
      out_hdr_found  <= 1'b0;
      out_hdr_median <= '0;
    end else begin
      case (state)
        IDLE: if (in_cfg_rd) begin
          pivot_q    <= in_cfg_pivot;
          size_q     <= size_c;
          rank_q     <= rank_c;
          fill_cnt   <= '0;
          lower_cnt  <= '0;
          equal_cnt  <= '0;
          larger_cnt <= '0;
          lower_min  <= '1;
          lower_max  <= '0;
          larger_min <= '1;
          larger_max <= '0;
          state      <= (size_c == '0) ? DECIDE : FILL;
        end
        FILL: if (in_px_rd) begin
          fill_cnt <= fill_cnt + SIZE_W'(1);
          if (px_lt) begin
            lower_cnt <= lower_cnt + SIZE_W'(1);
            if (in_px < lower_min) lower_min <= in_px;
            if (in_px > lower_max) lower_max <= in_px;
          end else if (px_gt) begin
            larger_cnt <= larger_cnt + SIZE_W'(1);
            if (in_px < larger_min) larger_min <= in_px;
            if (in_px > larger_max) larger_max <= in_px;
          end else begin
            equal_cnt <= equal_cnt + SIZE_W'(1);
          end
          if (fill_cnt == size_q - SIZE_W'(1)) state <= DECIDE;
        end
        DECIDE: begin
          send_idx   <= '0;
          sel_larger <= !pick_lower;
          state      <= HDR;
          if ((size_q == '0) || pick_equal) begin
            out_hdr_found  <= 1'b1;
            out_hdr_median <= pivot_q;
            out_hdr_pivot  <= pivot_q;
            out_hdr_size   <= '0;
            out_hdr_rank   <= '0;
          end else if ((pick_cnt == SIZE_W'(1)) || (pick_min == pick_max)) begin
            out_hdr_found  <= 1'b1;
            out_hdr_median <= pick_min;
            out_hdr_pivot  <= pick_min;
            out_hdr_size   <= '0;
            out_hdr_rank   <= '0;
          end else begin
            out_hdr_found  <= 1'b0;
            out_hdr_median <= '0;
            out_hdr_pivot  <= DATA_W'(({1'b0, pick_min} + {1'b0, pick_max}) >> 1);
            out_hdr_size   <= pick_cnt;
            out_hdr_rank   <= pick_lower ? rank_q : rank_larger;
          end
        end
        HDR: if (out_hdr_wr) begin
          state <= (out_hdr_size == '0) ? IDLE : SEND;
        end
        SEND: if (out_px_wr) begin
          send_idx <= send_idx + SIZE_W'(1);
          if (send_idx == out_hdr_size - SIZE_W'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_median_partition_stage.sv
// Directed scoreboard bench for median_partition_stage with FWFT FIFO models
// on the inputs and a negedge monitor comparing pushed headers and pixels.
module tb_median_partition_stage;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int SIZE_W = $clog2(DEPTH + 1);

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [DATA_W-1:0] in_cfg_pivot = '0;
  logic [SIZE_W-1:0] in_cfg_size = '0;
  logic [SIZE_W-1:0] in_cfg_rank = '0;
  logic              in_cfg_empty = 1'b1;
  logic              in_cfg_rd;
  logic [DATA_W-1:0] in_px = '0;
  logic              in_px_empty = 1'b1;
  logic              in_px_rd;
  logic [DATA_W-1:0] out_hdr_pivot;
  logic [SIZE_W-1:0] out_hdr_size;
  logic [SIZE_W-1:0] out_hdr_rank;
  logic              out_hdr_found;
  logic [DATA_W-1:0] out_hdr_median;
  logic              out_hdr_wr;
  logic              out_hdr_full = 1'b0;
  logic [DATA_W-1:0] out_px;
  logic              out_px_wr;
  logic              out_px_full = 1'b0;
  logic              busy;

  median_partition_stage #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .in_cfg_pivot(in_cfg_pivot), .in_cfg_size(in_cfg_size), .in_cfg_rank(in_cfg_rank),
    .in_cfg_empty(in_cfg_empty), .in_cfg_rd(in_cfg_rd),
    .in_px(in_px), .in_px_empty(in_px_empty), .in_px_rd(in_px_rd),
    .out_hdr_pivot(out_hdr_pivot), .out_hdr_size(out_hdr_size), .out_hdr_rank(out_hdr_rank),
    .out_hdr_found(out_hdr_found), .out_hdr_median(out_hdr_median),
    .out_hdr_wr(out_hdr_wr), .out_hdr_full(out_hdr_full),
    .out_px(out_px), .out_px_wr(out_px_wr), .out_px_full(out_px_full),
    .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [DATA_W-1:0] pivot;
    logic [SIZE_W-1:0] size;
    logic [SIZE_W-1:0] rank;
    logic              found;
    logic [DATA_W-1:0] median;
  } hdr_t;

  typedef struct packed {
    logic [DATA_W-1:0] pivot;
    logic [SIZE_W-1:0] size;
    logic [SIZE_W-1:0] rank;
  } cfg_t;

  cfg_t              cfg_q[$];
  logic [DATA_W-1:0] pix_q[$];
  hdr_t              exp_hdr_q[$];
  logic [DATA_W-1:0] exp_px_q[$];

  int compared   = 0;
  int mismatched = 0;

  bit cfg_rd_f, px_rd_f;
  int px_push_cnt = 0;
  bit toggle_en = 0, toggle = 0;
  bit stall_armed = 0;
  int stall_base = 0, stall_left = 0;

  hdr_t mon_got, mon_exp;
  logic [DATA_W-1:0] mon_px;

  function automatic hdr_t mk_hdr(input int p, input int s, input int r, input int f, input int m);
    hdr_t h;
    h.pivot  = DATA_W'(p);
    h.size   = SIZE_W'(s);
    h.rank   = SIZE_W'(r);
    h.found  = f[0];
    h.median = DATA_W'(m);
    return h;
  endfunction

  task automatic push_cfg(input int p, input int s, input int r);
    cfg_t c;
    c.pivot = DATA_W'(p);
    c.size  = SIZE_W'(s);
    c.rank  = SIZE_W'(r);
    cfg_q.push_back(c);
  endtask

  // Monitor: transfers seen here commit on the following rising edge.
  always @(negedge clock) begin
    cfg_rd_f = in_cfg_rd;
    px_rd_f  = in_px_rd;
    if (out_px_full) begin
      compared++;
      if (out_px_wr) begin
        mismatched++;
        $display("FAIL px_wr_while_full: out_px_wr=%0b required 0", out_px_wr);
      end else if (exp_px_q.size() > 0 && out_px !== exp_px_q[0]) begin
        mismatched++;
        $display("FAIL px_stall_hold: out_px=%0d required %0d", out_px, exp_px_q[0]);
      end
    end
    if (in_px_empty && reset) begin
      compared++;
      if (in_px_rd) begin
        mismatched++;
        $display("FAIL px_rd_while_empty: in_px_rd=%0b required 0", in_px_rd);
      end
    end
    if (out_hdr_wr) begin
      mon_got = mk_hdr(out_hdr_pivot, out_hdr_size, out_hdr_rank, out_hdr_found, out_hdr_median);
      compared++;
      if (exp_hdr_q.size() == 0) begin
        mismatched++;
        $display("FAIL hdr_unexpected: pivot=%0d size=%0d rank=%0d found=%0d median=%0d, none required",
                 mon_got.pivot, mon_got.size, mon_got.rank, mon_got.found, mon_got.median);
      end else begin
        mon_exp = exp_hdr_q.pop_front();
        if (mon_got !== mon_exp) begin
          mismatched++;
          $display("FAIL hdr: got pivot=%0d size=%0d rank=%0d found=%0d median=%0d, required pivot=%0d size=%0d rank=%0d found=%0d median=%0d",
                   mon_got.pivot, mon_got.size, mon_got.rank, mon_got.found, mon_got.median,
                   mon_exp.pivot, mon_exp.size, mon_exp.rank, mon_exp.found, mon_exp.median);
        end
      end
    end
    if (out_px_wr) begin
      px_push_cnt++;
      compared++;
      if (exp_hdr_q.size() != 0) begin
        mismatched++;
        $display("FAIL px_before_hdr: out_px=%0d pushed while %0d header(s) still owed", out_px, exp_hdr_q.size());
      end else if (exp_px_q.size() == 0) begin
        mismatched++;
        $display("FAIL px_unexpected: out_px=%0d, none required", out_px);
      end else begin
        mon_px = exp_px_q.pop_front();
        if (out_px !== mon_px) begin
          mismatched++;
          $display("FAIL px: out_px=%0d required %0d", out_px, mon_px);
        end
      end
    end
  end

  // Input FIFO models and output backpressure, updated just after each edge.
  always @(posedge clock) begin
    #1;
    if (cfg_rd_f && cfg_q.size() > 0) void'(cfg_q.pop_front());
    if (px_rd_f && pix_q.size() > 0) void'(pix_q.pop_front());
    cfg_rd_f = 0;
    px_rd_f  = 0;
    toggle = toggle_en ? ~toggle : 1'b0;
    in_cfg_empty = (cfg_q.size() == 0);
    if (cfg_q.size() > 0) begin
      in_cfg_pivot = cfg_q[0].pivot;
      in_cfg_size  = cfg_q[0].size;
      in_cfg_rank  = cfg_q[0].rank;
    end
    in_px_empty = (pix_q.size() == 0) || toggle;
    in_px = (pix_q.size() > 0) ? pix_q[0] : '0;
    if (stall_armed && px_push_cnt > stall_base && stall_left > 0) begin
      out_px_full = 1'b1;
      stall_left--;
    end else begin
      out_px_full = 1'b0;
    end
  end

  task automatic check_quiet(input string name);
    compared++;
    if ({out_hdr_pivot, out_hdr_size, out_hdr_rank, out_hdr_found, out_hdr_median,
         out_hdr_wr, out_px, out_px_wr, busy, in_px_rd, in_cfg_rd} !== '0) begin
      mismatched++;
      $display("FAIL %s: pivot=%0d size=%0d rank=%0d found=%0d median=%0d hdr_wr=%0b px=%0d px_wr=%0b busy=%0b px_rd=%0b cfg_rd=%0b, required all 0",
               name, out_hdr_pivot, out_hdr_size, out_hdr_rank, out_hdr_found, out_hdr_median,
               out_hdr_wr, out_px, out_px_wr, busy, in_px_rd, in_cfg_rd);
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while ((exp_hdr_q.size() != 0 || exp_px_q.size() != 0 || cfg_q.size() != 0 || busy) && n < 400);
    @(negedge clock);
    compared++;
    if (exp_hdr_q.size() != 0 || exp_px_q.size() != 0 || busy) begin
      mismatched++;
      $display("FAIL %s_done: hdr owed=%0d px owed=%0d busy=%0b, required 0/0/0",
               name, exp_hdr_q.size(), exp_px_q.size(), busy);
      exp_hdr_q.delete();
      exp_px_q.delete();
    end
  endtask

  task automatic scen1;
    push_cfg(7, 5, 2);
    pix_q.push_back(9); pix_q.push_back(3); pix_q.push_back(7); pix_q.push_back(3); pix_q.push_back(12);
    exp_hdr_q.push_back(mk_hdr(7, 0, 0, 1, 7));
  endtask

  task automatic scen2;
    push_cfg(5, 5, 2);
    pix_q.push_back(9); pix_q.push_back(3); pix_q.push_back(7); pix_q.push_back(3); pix_q.push_back(12);
    exp_hdr_q.push_back(mk_hdr(9, 3, 0, 0, 0));
    exp_px_q.push_back(9); exp_px_q.push_back(7); exp_px_q.push_back(12);
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clock);
    #3;
    check_quiet("reset_state");
    @(posedge clock);
    #2 reset = 1'b1;

    scen1();
    wait_done("equal_found");

    scen2();
    wait_done("larger_forward");

    push_cfg(9, 4, 1);
    repeat (4) pix_q.push_back(5);
    exp_hdr_q.push_back(mk_hdr(5, 0, 0, 1, 5));
    wait_done("min_eq_max");

    push_cfg(2, 3, 7);
    pix_q.push_back(1); pix_q.push_back(2); pix_q.push_back(3);
    exp_hdr_q.push_back(mk_hdr(3, 0, 0, 1, 3));
    wait_done("rank_clamp");

    push_cfg(10, 4, 1);
    pix_q.push_back(8); pix_q.push_back(2); pix_q.push_back(6); pix_q.push_back(11);
    exp_hdr_q.push_back(mk_hdr(5, 3, 1, 0, 0));
    exp_px_q.push_back(8); exp_px_q.push_back(2); exp_px_q.push_back(6);
    wait_done("lower_forward");

    push_cfg(4, 0, 3);
    exp_hdr_q.push_back(mk_hdr(4, 0, 0, 1, 4));
    wait_done("size_zero");

    toggle_en   = 1;
    stall_base  = px_push_cnt;
    stall_left  = 3;
    stall_armed = 1;
    scen2();
    wait_done("stalled");
    toggle_en   = 0;
    stall_armed = 0;

    scen2();
    n = 0;
    while (px_push_cnt == 0 || exp_px_q.size() > 2) begin
      @(negedge clock);
      n++;
      if (n > 200) break;
    end
    compared++;
    if (exp_px_q.size() != 2) begin
      mismatched++;
      $display("FAIL reset_setup: px owed=%0d required 2", exp_px_q.size());
    end
    @(posedge clock);
    #2 reset = 1'b0;
    #1 check_quiet("reset_mid_send");
    exp_px_q.delete();
    exp_hdr_q.delete();
    pix_q.delete();
    scen1();
    repeat (2) @(posedge clock);
    #3;
    check_quiet("held_in_reset");
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    compared++;
    if (in_cfg_rd !== 1'b1) begin
      mismatched++;
      $display("FAIL cfg_rd_after_reset: in_cfg_rd=%0b required 1", in_cfg_rd);
    end
    wait_done("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
